// File: rtl/aoc4_pkg.sv
// Common types and constants for the grid row loading path.
package aoc4_pkg;
`include "aoc4.svh"

  localparam int ROW_W = `GRID_VEC_ALIGN_N;
  localparam int COL_W = $clog2(ROW_W + 1);

  typedef enum logic [1:0] {FILL, WRITE, DONE, ERR} state_e;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_NL    = 8'h0A;
endpackage

// File: rtl/grid_row_packer_if.sv
// Byte-stream input and row-RAM write port bundles for the grid row packer.
interface grid_byte_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

interface grid_ram_if #(parameter int ADDR_WIDTH = 4);
  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic [aoc4_pkg::ROW_W-1:0]   ram_write_data;
  logic                         ram_bank_sel;
  logic                         ram_write_en;

  modport master (output ram_addr, ram_write_data, ram_bank_sel, ram_write_en);
  modport slave  (input ram_addr, ram_write_data, ram_bank_sel, ram_write_en);
endinterface

// File: rtl/aoc4.svh
// Shared build-time geometry for the grid loader: width of one packed grid row.
`ifndef AOC4_SVH
`define AOC4_SVH
`define GRID_VEC_ALIGN_N 8
`endif

// File: rtl/grid_char_decode.sv
// Classifies one input byte as a grid cell (and its value) or a row terminator.
module grid_char_decode
  import aoc4_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_cell,
  output logic       cell_bit,
  output logic       is_newline
);

  assign is_cell    = (char_i == CH_ROLL) || (char_i == CH_EMPTY);
  assign cell_bit   = (char_i == CH_ROLL);
  assign is_newline = (char_i == CH_NL);

endmodule

// File: rtl/grid_row_packer.sv
// Packs '@'/'.' text lines into row vectors and writes them to the row RAM.
module grid_row_packer
  import aoc4_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  grid_byte_if.slave            in_if,
  grid_ram_if.master            ram_if,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   row_count
);

  localparam logic [ADDR_WIDTH:0] ROW_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_WIDTH:0] row_idx_q, row_idx_d;
  logic [ROW_W-1:0]    row_buf_q, row_buf_d;
  logic                last_q, last_d;

  logic             is_cell, cell_bit, is_newline, accept;
  logic [COL_W-1:0] col_after;
  logic [ROW_W-1:0] buf_after;

  grid_char_decode u_decode (
    .char_i     (in_if.in_data),
    .cell_bit   (cell_bit),
    .is_cell    (is_cell),
    .is_newline (is_newline)
  );

  assign accept = in_if.in_valid && (state_q == FILL);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      col_q     <= '0;
      row_idx_q <= '0;
      row_buf_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      row_buf_q <= row_buf_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first so no path leaves a signal unassigned (no latch).
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    row_buf_d = row_buf_q;
    last_d    = last_q;
    col_after = col_q;
    buf_after = row_buf_q;

    if (start) begin
      // An in-flight WRITE still reaches the RAM: the port decodes from state_q.
      state_d   = FILL;
      col_d     = '0;
      row_idx_d = '0;
      row_buf_d = '0;
      last_d    = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (is_cell && (col_q == COL_W'(ROW_W))) begin
              state_d = ERR;
            end else begin
              if (is_cell) begin
                buf_after = row_buf_q | (ROW_W'(cell_bit) << col_q);
                col_after = col_q + COL_W'(1);
              end
              col_d     = col_after;
              row_buf_d = buf_after;
              if ((is_newline || in_if.in_last) && (col_after != '0)) begin
                if (row_idx_q == ROW_LIMIT) begin
                  state_d = ERR;
                end else begin
                  state_d = WRITE;
                  last_d  = in_if.in_last;
                end
              end else if (in_if.in_last) begin
                state_d = DONE;
              end
            end
          end
        end
        WRITE: begin
          row_idx_d = row_idx_q + (ADDR_WIDTH + 1)'(1);
          col_d     = '0;
          row_buf_d = '0;
          last_d    = 1'b0;
          state_d   = last_q ? DONE : FILL;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_if.in_ready        = (state_q == FILL);
    ram_if.ram_bank_sel   = (state_q == WRITE);
    ram_if.ram_write_en   = (state_q == WRITE);
    ram_if.ram_addr       = (state_q == WRITE) ? row_idx_q[ADDR_WIDTH-1:0] : '0;
    ram_if.ram_write_data = (state_q == WRITE) ? row_buf_q : '0;
    done                  = (state_q == DONE);
    error                 = (state_q == ERR);
    row_count             = row_idx_q;
  end

endmodule

// File: tb/tb_grid_row_packer.sv
// Scoreboard bench for grid_row_packer: expected RAM writes queued as rows are sent.
module tb_grid_row_packer;
  localparam int AW    = 4;
  localparam int DEP   = 16;
  localparam int ROW_W = aoc4_pkg::ROW_W;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [ROW_W-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          done, error;
  logic [AW:0]   row_count;

  grid_byte_if             byte_if ();
  grid_ram_if #(.ADDR_WIDTH(AW)) ram_if ();

  grid_row_packer #(.ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .in_if     (byte_if),
    .ram_if    (ram_if),
    .done      (done),
    .error     (error),
    .row_count (row_count)
  );

  always #5 clock = ~clock;

  int  n_compared   = 0;
  int  n_mismatched = 0;
  wr_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && (ram_if.ram_write_en || ram_if.ram_bank_sel)) begin
      check("ram_bank_sel", ram_if.ram_bank_sel, 1'b1);
      check("ram_write_en", ram_if.ram_write_en, 1'b1);
      if (sb.size() == 0) begin
        check("write_unexpected", ram_if.ram_write_en, 1'b0);
      end else begin
        wr_t exp_wr;
        exp_wr = sb.pop_front();
        check("ram_write", {ram_if.ram_addr, ram_if.ram_write_data}, exp_wr);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    int waited = 0;
    @(negedge clock);
    byte_if.in_valid = 1'b1;
    byte_if.in_data  = b;
    byte_if.in_last  = last;
    while (!byte_if.in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!byte_if.in_ready) begin
      check("ready_timeout", byte_if.in_ready, 1'b1);
      byte_if.in_valid = 1'b0;
    end else begin
      @(posedge clock);
    end
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
  endtask

  task automatic idle();
    @(negedge clock);
    byte_if.in_valid = 1'b0;
    byte_if.in_last  = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || error) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!(done || error)) check(tag, done | error, 1'b1);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clock);
    byte_if.in_valid = 1'b0;
    byte_if.in_last  = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_rows"}, row_count, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    start            = 1'b0;
    byte_if.in_valid = 1'b0;
    byte_if.in_data  = 8'h00;
    byte_if.in_last  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", byte_if.in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_rows", row_count, '0);
    check("rst_ram", {ram_if.ram_bank_sel, ram_if.ram_write_en,
                      ram_if.ram_addr, ram_if.ram_write_data}, '0);
    reset_n = 1'b1;

    // Three rows, last one terminated by in_last rather than newline.
    sb.push_back('{addr: 4'd0, data: 8'b0000_0101});
    sb.push_back('{addr: 4'd1, data: 8'b0000_0110});
    sb.push_back('{addr: 4'd2, data: 8'b0000_0001});
    send_str("@.@\n.@@\n", 1'b0);
    send_str("@", 1'b1);
    idle();
    wait_end("t1_timeout");
    check("t1_done", done, 1'b1);
    check("t1_error", error, 1'b0);
    check("t1_rows", row_count, 5'd3);
    check("t1_ready_low", byte_if.in_ready, 1'b0);

    // Restart, then a back-to-back 5-cell row: in_ready drops for one WRITE cycle.
    pulse_start("t2_start");
    sb.push_back('{addr: 4'd0, data: 8'h0B});
    send_str("@@.@.\n", 1'b0);
    @(negedge clock);
    check("t2_ready_drop", byte_if.in_ready, 1'b0);
    check("t2_we_pulse", ram_if.ram_write_en, 1'b1);
    @(negedge clock);
    byte_if.in_valid = 1'b0;
    check("t2_ready_back", byte_if.in_ready, 1'b1);
    check("t2_we_end", ram_if.ram_write_en, 1'b0);
    check("t2_mid_done", done, 1'b0);
    check("t2_mid_error", error, 1'b0);
    check("t2_mid_rows", row_count, 5'd1);
    sb.push_back('{addr: 4'd1, data: 8'h02});
    send_str(".@", 1'b1);
    idle();
    wait_end("t2_timeout");
    check("t2_done", done, 1'b1);
    check("t2_rows", row_count, 5'd2);

    // Blank lines and CR are tolerated; in_last on the terminating newline.
    pulse_start("t3_start");
    sb.push_back('{addr: 4'd0, data: 8'h01});
    send_str("\n\n@.\r\n", 1'b1);
    idle();
    wait_end("t3_timeout");
    check("t3_done", done, 1'b1);
    check("t3_rows", row_count, 5'd1);

    // One cell too many on a row: error, nothing written.
    pulse_start("t4_start");
    for (int i = 0; i < ROW_W + 1; i++) send_byte(8'h40, 1'b0);
    idle();
    wait_end("t4_timeout");
    check("t4_error", error, 1'b1);
    check("t4_done", done, 1'b0);
    check("t4_rows", row_count, '0);
    check("t4_ready", byte_if.in_ready, 1'b0);

    // DEPTH rows fill the RAM; the next row raises error instead of writing.
    pulse_start("t5_start");
    for (int i = 0; i < DEP; i++) begin
      sb.push_back('{addr: AW'(i), data: (i % 2 == 1) ? 8'h02 : 8'h01});
      send_str((i % 2 == 1) ? ".@\n" : "@\n", 1'b0);
    end
    send_str("@\n", 1'b0);
    idle();
    wait_end("t5_timeout");
    check("t5_error", error, 1'b1);
    check("t5_rows", row_count, 5'd16);

    // Reset mid-row discards the partial row; loading resumes at row 0.
    pulse_start("t6_start");
    send_str("@.@", 1'b0);
    idle();
    reset_n = 1'b0;
    @(negedge clock);
    check("t6_rst_rows", row_count, '0);
    check("t6_rst_ready", byte_if.in_ready, 1'b1);
    reset_n = 1'b1;
    sb.push_back('{addr: 4'd0, data: 8'h01});
    send_str("@\n", 1'b0);
    idle();
    repeat (3) @(negedge clock);
    check("t6_rows", row_count, 5'd1);
    check("t6_done", done, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
